imem_boot_ctrl: RTL
===================

Name: imem_boot_ctrl

Overview:
- Program-load and run sequencer for the instruction fetch stage and its instruction memory.
- Accepts a framed word stream from the host: a length header, N payload words, then a checksum word.
- Writes the payload into instruction memory through the memory's write port (address, data, write enable).
- After a good checksum it releases the core to run from START_ADDR. It also handles host stop commands and halt requests from the core.

Parameters:
- START_ADDR, 32'h8000_0000, byte address of payload word 0; also the core restart address.
- DEPTH, 12, log2 of instruction memory depth in words; maximum payload is 2**DEPTH words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_data  in  32  host stream word
- s_valid  in  1  host word valid
- s_ready  out  1  controller accepts word; a beat transfers when s_valid && s_ready
- cmd_stop  in  1  host pulse: abort load or stop the core
- core_halt  in  1  core requests halt (e.g. ebreak retired)
- insn_addr  out  32  instruction memory write byte address
- insn_din  out  32  instruction memory write data
- insn_we  out  1  instruction memory write enable
- core_reset  out  1  reset to the fetch stage and core
- core_run  out  1  run enable to the fetch stage
- state  out  3  current FSM state code
- err_code  out  2  0 none, 1 BADLEN, 2 BADSUM, 3 ABORT
- load_count  out  DEPTH+1  payload words written in the current or last load

Behaviour:
- FSM states and codes: IDLE=0, LOAD=1, CSUM=2, RUN=3, HALT=4, ERR=5.
- Reset values: state IDLE, s_ready 0, insn_we 0, insn_addr START_ADDR, insn_din 0, core_reset 1, core_run 0, err_code 0, load_count 0.
- All outputs are registered. s_ready is 1 only in IDLE, LOAD and CSUM, and is driven from the registered state.
- IDLE, on a header beat (value N):
  - N==0 or N>2**DEPTH: go to ERR with err_code=BADLEN.
  - Otherwise: latch N, clear load_count, clear the running sum, clear err_code, go to LOAD.
- LOAD, on each beat:
  - Next cycle: insn_we=1, insn_din=s_data, insn_addr=START_ADDR+4*load_count (pre-increment value). Write latency is 1 cycle after the accepted beat.
  - Same clock edge: load_count increments and sum += s_data (mod 2**32).
  - On the beat that makes load_count==N, go to CSUM.
  - No beat: insn_we=0, no change.
- CSUM, on a beat:
  - s_data==sum: go to RUN.
  - Otherwise: go to ERR with err_code=BADSUM.
  - No memory write occurs in CSUM.
- core_reset is 1 in IDLE, LOAD, CSUM and ERR, and 0 in RUN and HALT. core_run is 1 only in RUN.
- Entering RUN therefore releases the core with the fetch PC at START_ADDR. The last memory write has completed at least 1 cycle before core_reset falls.
- RUN: core_halt goes to HALT; core_run drops next cycle and core_reset stays 0, so the fetch stage freezes.
- HALT: core_run=0 and the core is not reset.
- RUN or HALT, cmd_stop: go to IDLE; core_reset rises and err_code is unchanged.
- LOAD or CSUM, cmd_stop: go to ERR with err_code=ABORT. Words already written stay in memory.
- ERR: s_ready=0. cmd_stop returns to IDLE and clears err_code.
- Priority in the same cycle: reset > cmd_stop > core_halt > stream beat.
- reset mid-load: immediate return to IDLE, insn_we low next cycle. Partially written memory is not scrubbed.
- Back-to-back beats at one per cycle must be sustained in LOAD; no bubbles are inserted.
- insn_addr wraps modulo 2**32. This cannot occur for legal N when START_ADDR is aligned.

Decomposition:
- Package imem_boot_pkg: the state_t enum with the codes above; the err_t enum (ERR_NONE, ERR_BADLEN, ERR_BADSUM, ERR_ABORT); a function for max words given DEPTH.
- Sub-module boot_frame_rx: stream handshake, word counter and checksum accumulator. It reports hdr_ok, hdr_bad, payload_beat, last_payload and csum_match.
- The top level holds the FSM, the memory write port registers and the core control registers.

Test Plan:
- Load N=3, words 0x00000013, 0x00100093, 0x00000073, checksum 0x00100119 -> three writes at 0x80000000/04/08 one cycle after each beat; core_reset falls and core_run=1 one cycle after the checksum beat; state=3.
- Same frame with checksum 0x00100118 -> no RUN; state=5, err_code=2, core_reset stays 1; cmd_stop -> state=0, err_code=0.
- Header 0 and header 0x00001001 (DEPTH=12) -> state=5, err_code=1, insn_we never asserted.
- N=4, cmd_stop after the 2nd payload beat -> err_code=3, load_count=2, no further writes; then a valid N=1 frame loads and reaches RUN.
- In RUN, pulse core_halt -> core_run=0, core_reset=0, state=4; then cmd_stop -> core_reset=1, state=0.
- s_valid held high with 4096 payload words at full rate -> 4096 consecutive insn_we cycles, final insn_addr 0x80003FFC, RUN on a correct checksum.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types for the instruction-memory boot controller.
//   state_t : FSM state codes as seen on the state output
//   err_t   : error codes as seen on the err_code output
//   max_words(depth) : largest legal payload length for a 2**depth word memory
package imem_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_HALT = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_BADLEN = 2'd1,
        ERR_BADSUM = 2'd2,
        ERR_ABORT  = 2'd3
    } err_t;

    function automatic logic [31:0] max_words(input int unsigned depth);
        return 32'd1 << depth;
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_frame_rx.sv
// Frame receiver: qualifies stream beats against the current FSM state, keeps
// the payload length, word counter and running checksum.
//   clk, reset       : clock, synchronous active-high reset
//   i_data/i_valid   : host stream word and valid
//   i_ready          : registered ready from the top (beat = valid && ready)
//   i_stop           : host stop; a beat in the same cycle is dropped
//   i_state          : current FSM state
//   o_hdr_ok/bad     : header beat in IDLE with legal / illegal length
//   o_payload_beat   : payload beat accepted in LOAD
//   o_last_payload   : this payload beat completes the frame
//   o_csum_beat      : checksum beat in CSUM; o_csum_match says it equals the sum
//   o_count          : payload words accepted in the current or last load
module boot_frame_rx
    import imem_boot_pkg::*;
#(
    parameter int unsigned DEPTH = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   i_data,
    input  logic          i_valid,
    input  logic          i_ready,
    input  logic          i_stop,
    input  state_t        i_state,
    output logic          o_hdr_ok,
    output logic          o_hdr_bad,
    output logic          o_payload_beat,
    output logic          o_last_payload,
    output logic          o_csum_beat,
    output logic          o_csum_match,
    output logic [DEPTH:0] o_count
);

    localparam int unsigned CW = DEPTH + 1;

    logic [CW-1:0] r_len;
    logic [CW-1:0] r_count;
    logic [31:0]   r_sum;

    logic          w_beat;
    logic          w_len_legal;
    logic [CW-1:0] w_count_inc;

    // Stop outranks a stream beat, so a beat coinciding with stop is ignored.
    assign w_beat      = i_valid && i_ready && !i_stop;
    assign w_len_legal = (i_data != 32'd0) && (i_data <= max_words(DEPTH));
    assign w_count_inc = r_count + CW'(1);

    assign o_hdr_ok       = w_beat && (i_state == ST_IDLE) && w_len_legal;
    assign o_hdr_bad      = w_beat && (i_state == ST_IDLE) && !w_len_legal;
    assign o_payload_beat = w_beat && (i_state == ST_LOAD);
    assign o_last_payload = o_payload_beat && (w_count_inc == r_len);
    assign o_csum_beat    = w_beat && (i_state == ST_CSUM);
    assign o_csum_match   = (i_data == r_sum);
    assign o_count        = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len   <= '0;
            r_count <= '0;
            r_sum   <= '0;
        end else if (o_hdr_ok) begin
            r_len   <= i_data[CW-1:0];
            r_count <= '0;
            r_sum   <= '0;
        end else if (o_payload_beat) begin
            r_count <= w_count_inc;
            r_sum   <= r_sum + i_data;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Program-load and run sequencer for the fetch stage and instruction memory.
// Takes a framed host stream (length, N payload words, checksum), writes the
// payload to instruction memory from START_ADDR upward and, on a good checksum,
// releases the core to run from START_ADDR. Handles host stop and core halt.
//   clk, reset              : clock, synchronous active-high reset
//   s_data/s_valid/s_ready  : host word stream
//   cmd_stop                : host abort/stop pulse
//   core_halt               : halt request from the core
//   insn_addr/din/we        : instruction memory write port (1 cycle after beat)
//   core_reset, core_run    : core control
//   state, err_code         : status; load_count : words written in last load
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH      = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    s_data,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic           cmd_stop,
    input  logic           core_halt,
    output logic [31:0]    insn_addr,
    output logic [31:0]    insn_din,
    output logic           insn_we,
    output logic           core_reset,
    output logic           core_run,
    output logic [2:0]     state,
    output logic [1:0]     err_code,
    output logic [DEPTH:0] load_count
);

    state_t      r_state;
    err_t        r_err;
    logic        r_s_ready;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic        r_core_reset;
    logic        r_core_run;

    state_t         w_next_state;
    err_t           w_next_err;
    logic           w_hdr_ok;
    logic           w_hdr_bad;
    logic           w_payload_beat;
    logic           w_last_payload;
    logic           w_csum_beat;
    logic           w_csum_match;
    logic [DEPTH:0] w_count;

    boot_frame_rx #(
        .DEPTH (DEPTH)
    ) u_frame_rx (
        .clk            (clk),
        .reset          (reset),
        .i_data         (s_data),
        .i_valid        (s_valid),
        .i_ready        (r_s_ready),
        .i_stop         (cmd_stop),
        .i_state        (r_state),
        .o_hdr_ok       (w_hdr_ok),
        .o_hdr_bad      (w_hdr_bad),
        .o_payload_beat (w_payload_beat),
        .o_last_payload (w_last_payload),
        .o_csum_beat    (w_csum_beat),
        .o_csum_match   (w_csum_match),
        .o_count        (w_count)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_err   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_bad) begin
                    w_next_state = ST_ERR;
                    w_next_err   = ERR_BADLEN;
                end else if (w_hdr_ok) begin
                    w_next_state = ST_LOAD;
                    w_next_err   = ERR_NONE;
                end
            end
            ST_LOAD: begin
                if (cmd_stop) begin
                    w_next_state = ST_ERR;
                    w_next_err   = ERR_ABORT;
                end else if (w_last_payload) begin
                    w_next_state = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (cmd_stop) begin
                    w_next_state = ST_ERR;
                    w_next_err   = ERR_ABORT;
                end else if (w_csum_beat) begin
                    if (w_csum_match) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_ERR;
                        w_next_err   = ERR_BADSUM;
                    end
                end
            end
            ST_RUN: begin
                if (cmd_stop) begin
                    w_next_state = ST_IDLE;
                end else if (core_halt) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                if (cmd_stop) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (cmd_stop) begin
                    w_next_state = ST_IDLE;
                    w_next_err   = ERR_NONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_err   = ERR_NONE;
            end
        endcase
    end

    // Status and core controls are decoded from the next state so they line up
    // with r_state in the same cycle rather than lagging it by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_err        <= ERR_NONE;
            r_s_ready    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= START_ADDR;
            r_din        <= '0;
            r_core_reset <= 1'b1;
            r_core_run   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_err        <= w_next_err;
            r_s_ready    <= (w_next_state == ST_IDLE) || (w_next_state == ST_LOAD) ||
                            (w_next_state == ST_CSUM);
            r_core_reset <= !((w_next_state == ST_RUN) || (w_next_state == ST_HALT));
            r_core_run   <= (w_next_state == ST_RUN);
            r_we         <= w_payload_beat;
            if (w_payload_beat) begin
                // Address uses the pre-increment count of this beat.
                r_din  <= s_data;
                r_addr <= START_ADDR + (32'(w_count) << 2);
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign insn_we    = r_we;
    assign insn_addr  = r_addr;
    assign insn_din   = r_din;
    assign core_reset = r_core_reset;
    assign core_run   = r_core_run;
    assign state      = r_state;
    assign err_code   = r_err;
    assign load_count = w_count;

endmodule
